mac_burst_controller: RTL and testbench

- Parametrised successor to the single-word memory access controller that sits between the DLX control state machine and the external bus.
- Runs single or multi-word (burst) reads/writes on the AS_N/WR_N/ACK_N handshake, e.g. a 3x3 pixel-neighbourhood fetch for the sharpening extension.
- Generates per-word addresses, stalls the control FSM through stop_n/busy, and detects bus timeouts.
- Address/timing only; the datapath moves the data.

---
 rtl/mac_burst_controller.sv | 206 ++++++++++++++++++++
 tb/tb_mac_burst_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_burst_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mac_burst_controller
//  Purpose  : Memory access controller between the DLX control FSM and the
//             external bus. Runs single or multi-word read/write bursts on the
//             AS_N / WR_N / ACK_N handshake, generates per-word addresses,
//             stalls the control FSM while a transfer is open and flags bus
//             timeouts. Address and timing only; data moves in the datapath.
//  Ports    : clk, reset (sync, active high)
//             mr, mw          - read / write request levels
//             burst_len       - words per request (0 -> 1, clamped to MAX_BURST)
//             base_addr       - first word address
//             ACK_N           - bus acknowledge, active low
//             err_clr         - leaves the timeout error state
//             addr_out, AS_N, WR_N          - bus side
//             busy, stop_n                  - control FSM side
//             word_valid, word_idx, done    - per-word / per-burst status
//             timeout_err, MAC_STATE_OUT    - error flag and debug state
//  Revision : 1.0 - initial release
// ============================================================================
module mac_burst_controller #(
    parameter int ADDR_W      = 32,
    parameter int MAX_BURST   = 9,
    parameter int LEN_W       = 4,
    parameter int ADDR_STRIDE = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mr,
    input  logic              mw,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              ACK_N,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] addr_out,
    output logic              AS_N,
    output logic              WR_N,
    output logic              busy,
    output logic              stop_n,
    output logic              word_valid,
    output logic [LEN_W-1:0]  word_idx,
    output logic              done,
    output logic              timeout_err,
    output logic [2:0]        MAC_STATE_OUT
);

    localparam int                c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0]  c_MAX_LEN = LEN_W'(MAX_BURST);
    localparam logic [LEN_W-1:0]  c_ONE     = LEN_W'(1);
    localparam logic [ADDR_W-1:0] c_STRIDE  = ADDR_W'(ADDR_STRIDE);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_GAP  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_armed;
    logic                r_dir;        // 1 = write
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_TO_W-1:0]   r_to_cnt;

    logic                w_accept;
    logic                w_last;
    logic                w_to_hit;
    logic                w_dir_next;
    logic [LEN_W-1:0]    w_len_clamped;

    // A request is only taken while armed, so a request level still held
    // after DONE cannot start a second burst.
    assign w_accept   = (r_state == ST_IDLE) && (mr || mw) && r_armed;
    assign w_last     = (r_idx == (r_len - c_ONE));
    assign w_to_hit   = (r_to_cnt == c_TO_LAST);
    // Simultaneous mr and mw resolves to a read.
    assign w_dir_next = w_accept ? (mw && !mr) : r_dir;

    always_comb begin
        w_len_clamped = burst_len;
        if (burst_len == '0) begin
            w_len_clamped = c_ONE;
        end else if (burst_len > c_MAX_LEN) begin
            w_len_clamped = c_MAX_LEN;
        end
    end

    // ------------------------------------------------------------------
    // Next state and the only combinational output (stop_n)
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        stop_n = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_REQ;
                    stop_n = 1'b0;
                end
            end
            ST_REQ: begin
                stop_n = 1'b0;
                if (!ACK_N) begin
                    w_next = w_last ? ST_DONE : ST_GAP;
                end else if (w_to_hit) begin
                    w_next = ST_ERR;
                end
            end
            ST_GAP: begin
                stop_n = 1'b0;
                // The slave must release ACK_N before the next word starts.
                if (ACK_N) begin
                    w_next = ST_REQ;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                if (err_clr) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Burst bookkeeping: length, direction, word index, address, timeout
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed  <= 1'b1;
            r_dir    <= 1'b0;
            r_len    <= c_ONE;
            r_idx    <= '0;
            r_addr   <= '0;
            r_to_cnt <= '0;
        end else begin
            if ((r_state == ST_REQ) && (w_next == ST_DONE)) begin
                r_armed <= 1'b0;
            end else if (!mr && !mw) begin
                r_armed <= 1'b1;
            end

            if (w_accept) begin
                r_dir    <= w_dir_next;
                r_len    <= w_len_clamped;
                r_idx    <= '0;
                r_addr   <= base_addr;
                r_to_cnt <= '0;
            end else if ((r_state == ST_GAP) && ACK_N) begin
                // Running sum equals base + idx*stride modulo 2^ADDR_W.
                r_idx  <= r_idx + c_ONE;
                r_addr <= r_addr + c_STRIDE;
            end

            if (r_state == ST_REQ) begin
                r_to_cnt <= ACK_N ? (r_to_cnt + 1'b1) : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered bus/status outputs, decoded from the state being entered
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            AS_N        <= 1'b1;
            WR_N        <= 1'b1;
            busy        <= 1'b0;
            word_valid  <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            AS_N        <= (w_next != ST_REQ);
            WR_N        <= !((w_next == ST_REQ) && w_dir_next);
            busy        <= (w_next == ST_REQ) || (w_next == ST_GAP);
            word_valid  <= (r_state == ST_REQ) && !ACK_N;
            done        <= (w_next == ST_DONE);
            timeout_err <= (w_next == ST_ERR);
        end
    end

    assign addr_out      = r_addr;
    assign word_idx      = r_idx;
    assign MAC_STATE_OUT = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mac_burst_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_burst_controller
//  Purpose  : Self-checking bench for mac_burst_controller. Each burst is
//             driven as a transaction; the expected bus behaviour of every
//             cycle (address, strobes, word pulses, done, stall) is derived
//             from the burst parameters the bench chose.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_burst_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        mr;
    logic        mw;
    logic [3:0]  burst_len;
    logic [31:0] base_addr;
    logic        ACK_N;
    logic        err_clr;
    logic [31:0] addr_out;
    logic        AS_N;
    logic        WR_N;
    logic        busy;
    logic        stop_n;
    logic        word_valid;
    logic [3:0]  word_idx;
    logic        done;
    logic        timeout_err;
    logic [2:0]  MAC_STATE_OUT;

    int n_checks = 0;
    int n_fail   = 0;

    mac_burst_controller #(
        .ADDR_W      (32),
        .MAX_BURST   (9),
        .LEN_W       (4),
        .ADDR_STRIDE (1),
        .TIMEOUT     (255)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .mr            (mr),
        .mw            (mw),
        .burst_len     (burst_len),
        .base_addr     (base_addr),
        .ACK_N         (ACK_N),
        .err_clr       (err_clr),
        .addr_out      (addr_out),
        .AS_N          (AS_N),
        .WR_N          (WR_N),
        .busy          (busy),
        .stop_n        (stop_n),
        .word_valid    (word_valid),
        .word_idx      (word_idx),
        .done          (done),
        .timeout_err   (timeout_err),
        .MAC_STATE_OUT (MAC_STATE_OUT)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction. Word k waits a random number of REQ cycles
    // before ACK; ACK is then held low for a random number of GAP cycles.
    // abort_k >= 0 fires reset in the first REQ cycle of that word.
    task automatic burst(input bit rd, input bit wr, input logic [31:0] base,
                         input logic [3:0] blen, input int mind, input int maxd,
                         input int ming, input int maxg, input int hold,
                         input int abort_k);
        int          n;
        int          d;
        int          g;
        bit          is_wr;
        logic [31:0] exp_addr;
        n     = (blen == 0) ? 1 : ((blen > 9) ? 9 : int'(blen));
        is_wr = wr && !rd;

        // Acceptance cycle
        mr = rd; mw = wr; burst_len = blen; base_addr = base; ACK_N = 1'b1;
        #1;
        check_eq("accept_state", MAC_STATE_OUT, 0);
        check_eq("accept_stop_n", stop_n, 0);
        tick();
        // Sampled values must already be latched
        burst_len = 4'($urandom);
        base_addr = $urandom;

        for (int k = 0; k < n; k++) begin
            if (k == abort_k) begin
                ACK_N = 1'b1;
                reset = 1'b1;
                #1;
                tick();
                reset = 1'b0; mr = 1'b0; mw = 1'b0;
                #1;
                check_eq("rst_state", MAC_STATE_OUT, 0);
                check_eq("rst_as_n", AS_N, 1);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_idx", word_idx, 0);
                check_eq("rst_addr", addr_out, 0);
                check_eq("rst_stop_n", stop_n, 1);
                tick();
                return;
            end
            d        = $urandom_range(maxd, mind);
            exp_addr = base + 32'(k);
            for (int j = 0; j <= d; j++) begin
                ACK_N = (j == d) ? 1'b0 : 1'b1;
                #1;
                check_eq("req_state", MAC_STATE_OUT, 1);
                check_eq("req_as_n", AS_N, 0);
                check_eq("req_wr_n", WR_N, !is_wr);
                check_eq("req_addr", addr_out, exp_addr);
                check_eq("req_idx", word_idx, k);
                check_eq("req_busy", busy, 1);
                check_eq("req_stop_n", stop_n, 0);
                check_eq("req_wvalid", word_valid, 0);
                tick();
            end
            if (k == n - 1) begin
                ACK_N = 1'b1;
                #1;
                check_eq("done_state", MAC_STATE_OUT, 3);
                check_eq("done_pulse", done, 1);
                check_eq("done_wvalid", word_valid, 1);
                check_eq("done_idx", word_idx, k);
                check_eq("done_busy", busy, 0);
                check_eq("done_as_n", AS_N, 1);
                check_eq("done_wr_n", WR_N, 1);
                check_eq("done_stop_n", stop_n, 1);
                tick();
            end else begin
                g = $urandom_range(maxg, ming);
                for (int j = 0; j <= g; j++) begin
                    ACK_N = (j < g) ? 1'b0 : 1'b1;
                    #1;
                    check_eq("gap_state", MAC_STATE_OUT, 2);
                    check_eq("gap_as_n", AS_N, 1);
                    check_eq("gap_wr_n", WR_N, 1);
                    check_eq("gap_busy", busy, 1);
                    check_eq("gap_stop_n", stop_n, 0);
                    check_eq("gap_wvalid", word_valid, (j == 0));
                    check_eq("gap_idx", word_idx, k);
                    tick();
                end
            end
        end

        // Request level still held: no second burst may start
        for (int h = 0; h < hold; h++) begin
            #1;
            check_eq("hold_state", MAC_STATE_OUT, 0);
            check_eq("hold_as_n", AS_N, 1);
            check_eq("hold_stop_n", stop_n, 1);
            tick();
        end
        mr = 1'b0; mw = 1'b0;
        #1;
        check_eq("idle_state", MAC_STATE_OUT, 0);
        check_eq("idle_done", done, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_as_n", AS_N, 1);
        check_eq("idle_idx_hold", word_idx, n - 1);
        tick();
    endtask

    initial begin
        int          cnt;
        bit          rd;
        bit          wr;
        reset = 1'b1; mr = 1'b0; mw = 1'b0; ACK_N = 1'b1; err_clr = 1'b0;
        burst_len = 4'd0; base_addr = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_eq("reset_state", MAC_STATE_OUT, 0);
        check_eq("reset_as_n", AS_N, 1);
        check_eq("reset_wr_n", WR_N, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_wvalid", word_valid, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_terr", timeout_err, 0);
        check_eq("reset_idx", word_idx, 0);
        check_eq("reset_addr", addr_out, 0);
        check_eq("reset_stop_n", stop_n, 1);
        tick();

        // Directed cases
        burst(1, 0, 32'h100,      4'd1,  0, 0, 0, 0, 0, -1);  // single read, 3 cycles
        burst(0, 1, 32'h200,      4'd9,  2, 2, 0, 0, 0, -1);  // write burst, ACK after 2
        burst(1, 0, 32'h300,      4'd0,  0, 1, 0, 1, 0, -1);  // len 0 -> 1 word
        burst(0, 1, 32'h400,      4'd15, 0, 1, 0, 1, 0, -1);  // clamp to 9
        burst(1, 0, 32'hFFFFFFFE, 4'd3,  0, 1, 0, 1, 0, -1);  // address wrap
        burst(1, 1, 32'h500,      4'd2,  0, 1, 0, 1, 0, -1);  // mr&mw -> read
        burst(1, 0, 32'h600,      4'd1,  0, 0, 0, 0, 3, -1);  // held request
        burst(0, 1, 32'h700,      4'd3,  0, 0, 4, 4, 0, -1);  // ACK stuck in GAP
        burst(1, 0, 32'h800,      4'd2,  200, 254, 0, 0, 0, -1); // counter clears per ACK
        burst(0, 1, 32'h900,      4'd9,  0, 1, 0, 1, 0, 3);   // reset during word 4

        // Timeout
        mr = 1'b1; mw = 1'b0; burst_len = 4'd1; base_addr = 32'h40; ACK_N = 1'b1;
        #1;
        check_eq("to_accept_stop_n", stop_n, 0);
        tick();
        cnt = 0;
        while (AS_N == 1'b0 && cnt < 400) begin
            cnt++;
            tick();
        end
        check_eq("to_req_cycles", cnt, 255);
        mr = 1'b0;
        #1;
        check_eq("to_state", MAC_STATE_OUT, 4);
        check_eq("to_flag", timeout_err, 1);
        check_eq("to_as_n", AS_N, 1);
        check_eq("to_busy", busy, 0);
        check_eq("to_stop_n", stop_n, 1);
        tick();
        tick();
        check_eq("to_sticky", timeout_err, 1);
        err_clr = 1'b1;
        #1;
        tick();
        err_clr = 1'b0;
        #1;
        check_eq("clr_state", MAC_STATE_OUT, 0);
        check_eq("clr_flag", timeout_err, 0);
        tick();

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            burst(rd, wr, $urandom, 4'($urandom_range(15, 0)),
                  0, 3, 0, 2, $urandom_range(2, 0), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
